crossbar_buffered: RTL

Parametrised successor to the combinational switch-traversal crossbar. Each output port has a 2-entry output skid buffer with valid/ready flow control toward the downstream link, so one output's backpressure never stalls another. It sits between switch allocation (which supplies per-output input selects) and the output link registers of the router.
Multicast (several outputs selecting the same input in one cycle) is legal. Illegal selects are dropped and flagged.

---
 rtl/crossbar_buffered.sv | 131 +++++++++++++
 1 files changed

// File: rtl/crossbar_buffered.sv
// crossbar_buffered
//
// Switch-traversal crossbar with a 2-entry skid buffer on each output.
// Switch allocation supplies one input select per output. A valid, legal
// select copies the chosen input flit into that output's buffer. Each
// buffer drains toward its downstream link under valid/ready handshaking.
// Backpressure on one output never stalls any other output.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   data_i       flit presented by each input port
//   sel_i        input index routed to each output
//   sel_valid_i  per-output transfer request
//   ready_o      per-output buffer can accept a flit (depends on state only)
//   data_o       head flit of each output buffer
//   valid_o      data_o holds a valid flit
//   ready_i      downstream accepts data_o this cycle
//   drop_o       registered 1-cycle pulse: an illegal select was dropped
module crossbar_buffered #(
  parameter int INPUT_NUM  = 5,
  parameter int OUTPUT_NUM = 5,
  parameter int FLIT_SIZE  = 8,
  localparam int SEL_SIZE  = $clog2(INPUT_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [INPUT_NUM-1:0][FLIT_SIZE-1:0]  data_i,
  input  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  sel_i,
  input  logic [OUTPUT_NUM-1:0]                sel_valid_i,
  output logic [OUTPUT_NUM-1:0]                ready_o,
  output logic [OUTPUT_NUM-1:0][FLIT_SIZE-1:0] data_o,
  output logic [OUTPUT_NUM-1:0]                valid_o,
  input  logic [OUTPUT_NUM-1:0]                ready_i,
  output logic [OUTPUT_NUM-1:0]                drop_o
);

  // The head register is what data_o shows; the skid register holds the
  // second entry. Keeping the head in its own register lets data_o keep its
  // last value once the buffer empties.
  logic [OUTPUT_NUM-1:0][1:0]           count_q, count_d;
  logic [OUTPUT_NUM-1:0][FLIT_SIZE-1:0] head_q, head_d;
  logic [OUTPUT_NUM-1:0][FLIT_SIZE-1:0] skid_q, skid_d;
  logic [OUTPUT_NUM-1:0]                drop_q, drop_d;

  logic [OUTPUT_NUM-1:0][FLIT_SIZE-1:0] route_flit;
  logic [OUTPUT_NUM-1:0]                route_legal;
  logic [OUTPUT_NUM-1:0]                push;
  logic [OUTPUT_NUM-1:0]                pop;

  // The select is decoded by explicit comparison against every input index.
  // A select value with no matching input is therefore illegal, which only
  // happens when INPUT_NUM is not a power of two.
  always_comb begin
    route_flit  = '0;
    route_legal = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        if (sel_i[o] == SEL_SIZE'(i)) begin
          route_flit[o]  = data_i[i];
          route_legal[o] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      ready_o[o] = (count_q[o] != 2'd2);
      valid_o[o] = (count_q[o] != 2'd0);
    end
  end

  assign push   = sel_valid_i & ready_o & route_legal;
  assign pop    = valid_o & ready_i;
  assign data_o = head_q;
  assign drop_o = drop_q;

  // Per-output buffer update. A request made while the buffer is full is
  // neither a push nor a drop; the requester is expected to hold it.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    drop_d  = sel_valid_i & ready_o & ~route_legal;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      case (count_q[o])
        2'd0: begin
          if (push[o]) begin
            head_d[o]  = route_flit[o];
            count_d[o] = 2'd1;
          end
        end
        2'd1: begin
          if (push[o] && pop[o]) begin
            head_d[o] = route_flit[o];
          end else if (push[o]) begin
            skid_d[o]  = route_flit[o];
            count_d[o] = 2'd2;
          end else if (pop[o]) begin
            count_d[o] = 2'd0;
          end
        end
        2'd2: begin
          if (pop[o]) begin
            head_d[o]  = skid_q[o];
            count_d[o] = 2'd1;
          end
        end
        default: begin
          count_d[o] = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
      skid_q  <= '0;
      drop_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      drop_q  <= drop_d;
    end
  end

endmodule
